mult_booth_seq: RTL and testbench
=================================

Name: mult_booth_seq

Overview:
- Iterative signed 32x32 multiplier using radix-4 Booth recoding.
- Companion of the sequential divider in the multdiv unit. It sits beside the divider under the same processor multdiv wrapper and uses the same start / result_rdy handshake.
- Produces a full 64-bit product, a 32-bit truncated result and an overflow exception flag.
- 16 iteration cycles per operation.

Parameters:
- WIDTH, 32, operand width in bits; must be even.
- ITERS, WIDTH/2 (16), number of radix-4 Booth steps.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; operands are sampled on the same edge.
- operand_a  input  WIDTH  signed multiplicand.
- operand_b  input  WIDTH  signed multiplier.
- product  output  2*WIDTH  signed full product; held until the next start.
- result  output  WIDTH  product[WIDTH-1:0].
- data_exception  output  1  high when the product does not fit in WIDTH signed bits; valid while result_rdy is high and held afterwards.
- result_rdy  output  1  one-cycle pulse marking completion.
- busy  output  1  high from the start edge until the completion edge.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; product=0, data_exception=0, result_rdy=0, busy=0; counter=0. Reset during RUN aborts the operation, and no result_rdy pulse is produced.
- States:
  - IDLE: start=1 -> latch the multiplicand M = sext(operand_a) to WIDTH+2 bits; load acc=0, mplr=operand_b, q_m1=0; counter=0; go to RUN.
  - RUN: each edge performs one Booth step, then counter+1. When counter reaches ITERS-1 the final step is taken and the state goes to DONE.
  - DONE: result_rdy=1 for exactly one cycle; busy=0; go to IDLE. start=1 while in DONE behaves as start in IDLE.
- Booth step:
  - Recode {mplr[1:0], q_m1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - acc (WIDTH+2 bits, signed) += recoded value.
  - Arithmetic-shift {acc, mplr, q_m1} right by 2; q_m1 takes the old mplr[1].
  - Use two's-complement negation and sign-extended M. No carries are dropped inside WIDTH+2 bits.
- Final product = {acc[WIDTH-1:0], mplr}.
- data_exception = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}}).
- Latency: start sampled at edge 0; RUN steps occur on edges 1..16; DONE is entered at edge 16; result_rdy is high during the cycle after edge 16 and deasserts at edge 17.
  - product, result and data_exception update at edge 16 and remain stable until the edge that completes the next operation.
- start while busy=1: restart. New operands are latched, counter=0, and the in-flight operation is discarded with no result_rdy pulse for it.
- Operands are not required to be held after the start edge.
- Boundary cases:
  - Either operand 0 -> product 0, exception 0.
  - -2^31 x -1 -> product 2^31, exception 1.
  - -2^31 x -2^31 -> product 2^62, exception 1.

Decomposition:
- Package mult_pkg holds: WIDTH and ITERS defaults; the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2); and the Booth select codes (ZERO, PM, P2M, NM, N2M).
- Sub-module booth_recode:
  - Combinational.
  - Inputs: the 3-bit window and M (WIDTH+2).
  - Output: the WIDTH+2 addend.
  - Instanced once.
- Everything else lives in mult_booth_seq: the FSM, counter, datapath registers and exception check.

Test Plan:
1. Reset then start with A=3, B=2 -> result_rdy pulses in the cycle after the 16th post-start edge; product=64'd6, result=6, data_exception=0; busy is high for exactly 16 cycles.
2. A=-7, B=5 -> product=-35 (64'hFFFF_FFFF_FFFF_FFDD), result=32'hFFFF_FFDD, exception=0. Also A=32'h7FFF_FFFF, B=2 -> product=64'h0000_0000_FFFF_FFFE, exception=1.
3. A=32'h8000_0000, B=32'hFFFF_FFFF -> product=64'h0000_0000_8000_0000, exception=1. A=32'h8000_0000, B=32'h8000_0000 -> product=64'h4000_0000_0000_0000, exception=1.
4. Start with A=100, B=100, then at the 5th cycle start again with A=-4, B=6 -> exactly one result_rdy pulse, 16 cycles after the second start; product=-24; the 10000 result never appears.
5. Start with A=12, B=12 and assert reset_n=0 asynchronously mid-RUN (between edges) -> all outputs go to 0 immediately; no result_rdy; a fresh start of 9x9 afterwards yields 81 at the normal latency.
6. Random signed operands (1000 pairs, back-to-back with start in the DONE cycle) -> product matches the reference A*B (64-bit signed); exception matches the overflow check; result_rdy count equals the start count.

Source files
------------

// File: rtl/mult_booth_seq_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int ITERS_DEFAULT = WIDTH_DEFAULT / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_sel_t;

endpackage

// File: rtl/mult_booth_seq_booth_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window onto the addend
// {0, +M, +2M, -M, -2M}, all carried at WIDTH+2 bits so nothing overflows.
module booth_recode
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] addend
);

  booth_sel_t       sel;
  logic [WIDTH+1:0] m2;

  assign m2 = {m[WIDTH:0], 1'b0};

  // Window decode to a select code
  always_comb begin
    sel = ZERO;
    case (window)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = N2M;
      3'b101, 3'b110: sel = NM;
      default:        sel = ZERO;
    endcase
  end

  // Select code to two's-complement addend
  always_comb begin
    addend = '0;
    case (sel)
      PM:      addend = m;
      P2M:     addend = m2;
      NM:      addend = '0 - m;
      N2M:     addend = '0 - m2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Iterative signed WIDTH x WIDTH multiplier, two Booth bits per cycle.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth step per edge, counter 0..ITERS-1
// DONE  | result_rdy pulse; start here begins the next operation at once
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITERS = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result,
  output logic                 data_exception,
  output logic                 result_rdy,
  output logic                 busy
);

  localparam int CNT_W = $clog2(ITERS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [WIDTH+1:0] m_reg;
  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic             q_m1;

  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH-1:0] mplr_nxt;
  logic             last_step;

  booth_recode #(.WIDTH(WIDTH)) u_recode (
    .window (({mplr[1:0], q_m1})),
    .m      (m_reg),
    .addend (addend)
  );

  assign sum       = acc + addend;
  assign acc_nxt   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
  assign mplr_nxt  = {sum[1:0], mplr[WIDTH-1:2]};
  assign last_step = (counter == CNT_W'(ITERS - 1));
  assign result    = product[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; start restarts from any state, discarding work in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    result_rdy = (state == DONE);
    busy       = (state == RUN);
  end

  // Datapath: operand load, Booth step with 2-bit arithmetic shift, final capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter        <= '0;
      m_reg          <= '0;
      acc            <= '0;
      mplr           <= '0;
      q_m1           <= 1'b0;
      product        <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      counter <= '0;
      m_reg   <= {{2{operand_a[WIDTH-1]}}, operand_a};
      acc     <= '0;
      mplr    <= operand_b;
      q_m1    <= 1'b0;
    end else if (state == RUN) begin
      acc     <= acc_nxt;
      mplr    <= mplr_nxt;
      q_m1    <= mplr[1];
      counter <= counter + 1'b1;
      if (last_step) begin
        product        <= {acc_nxt[WIDTH-1:0], mplr_nxt};
        data_exception <= (acc_nxt[WIDTH-1:0] != {WIDTH{mplr_nxt[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed and randomised checks of the sequential Booth multiplier.
module tb_mult_booth_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] operand_a, operand_b;
  logic [63:0] product;
  logic [31:0] result;
  logic        data_exception, result_rdy, busy;

  int n_checks = 0;
  int n_errors = 0;

  mult_booth_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .product        (product),
    .result         (result),
    .data_exception (data_exception),
    .result_rdy     (result_rdy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic ref_exc(input logic [63:0] p);
    return p[63:32] != {32{p[31]}};
  endfunction

  // One full operation: start at a negedge, track busy, latency and the pulse.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input logic exp_e);
    int lat, busy_cnt;
    @(negedge clk);
    operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = '0; operand_b = '0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (result_rdy) break;
      if (busy) busy_cnt++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd16);
    chk({tag, "_busy"}, 64'(busy_cnt), 64'd16);
    chk({tag, "_prod"}, product, exp_p);
    chk({tag, "_res"}, 64'(result), 64'(exp_p[31:0]));
    chk({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(result_rdy), 64'd0);
    chk({tag, "_hold"}, product, exp_p);
  endtask

  initial begin
    int cnt, lat, n;
    logic seen;
    logic [31:0] ra, rb;
    logic [63:0] rp;

    reset_n = 1'b0; start = 1'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod", product, 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(result_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    run_op("t1", 32'd3, 32'd2, 64'd6, 1'b0);
    run_op("t2a", 32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFDD, 1'b0);
    run_op("t2b", 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b1);
    run_op("t3a", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
    run_op("t3b", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    run_op("zero_a", 32'd0, 32'h1234_5678, 64'd0, 1'b0);
    run_op("zero_b", 32'h8765_4321, 32'd0, 64'd0, 1'b0);

    // Restart mid-operation: only the second operation may complete.
    @(negedge clk);
    operand_a = 32'd100; operand_b = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    operand_a = 32'hFFFF_FFFC; operand_b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (product == 64'd10000) seen = 1'b1;
      if (result_rdy) begin
        cnt++;
        if (cnt == 1) lat = i;
      end
    end
    chk("t4_cnt", 64'(cnt), 64'd1);
    chk("t4_lat", 64'(lat), 64'd16);
    chk("t4_prod", product, 64'hFFFF_FFFF_FFFF_FFE8);
    chk("t4_no10000", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    operand_a = 32'd12; operand_b = 32'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_prod", product, 64'd0);
    chk("t5_res", 64'(result), 64'd0);
    chk("t5_exc", 64'(data_exception), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rdy", 64'(result_rdy), 64'd0);
    cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (result_rdy) cnt++;
    end
    chk("t5_nopulse", 64'(cnt), 64'd0);
    run_op("t5_9x9", 32'd9, 32'd9, 64'd81, 1'b0);

    // Back-to-back random operations, next start issued in the DONE cycle.
    n = 1000; cnt = 0;
    ra = $urandom; rb = $urandom;
    @(negedge clk);
    operand_a = ra; operand_b = rb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      rp = ref_mul(ra, rb);
      lat = 0;
      while (lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (result_rdy) break;
      end
      if (result_rdy) cnt++;
      chk("rnd_prod", product, rp);
      chk("rnd_exc", 64'(data_exception), 64'(ref_exc(rp)));
      if (i < n - 1) begin
        ra = $urandom; rb = $urandom;
        if (i % 4 == 1) ra = {{16{ra[15]}}, ra[15:0]};
        operand_a = ra; operand_b = rb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("rnd_rdy_cnt", 64'(cnt), 64'(n));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
